// File: rtl/idu_sched_pkg.sv
// idu_sched_pkg: shared select codes, block FSM states and starvation limit
package idu_sched_pkg;
  localparam int WIDTH = 16;
  localparam int SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_PC = 3'd0;
  localparam logic [SEL_W-1:0] SEL_SP = 3'd1;
  localparam logic [SEL_W-1:0] SEL_HL = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DE = 3'd3;
  localparam logic [SEL_W-1:0] SEL_BC = 3'd4;
  localparam logic [2:0] STALL_LIMIT = 3'd4;
  typedef enum logic [1:0] {BLK_IDLE, BLK_HL, BLK_DE, BLK_BC} blk_state_e;
endpackage

// File: rtl/idu_sched_if.sv
// idu_sched_if: request/grant, IDU issue and write-back signals of the IDU sequencer
interface idu_sched_if;
  import idu_sched_pkg::*;
  logic pc_req, sp_req, sp_dec, blk_start, blk_dec, idu_zero;
  logic pc_gnt, sp_gnt, blk_busy, blk_done, blk_bc_zero;
  logic idu_valid, idu_dec, wb_en;
  logic [SEL_W-1:0] idu_sel, wb_sel;
  modport master(
    output pc_req, sp_req, sp_dec, blk_start, blk_dec, idu_zero,
    input pc_gnt, sp_gnt, blk_busy, blk_done, blk_bc_zero, idu_valid, idu_dec, idu_sel, wb_en, wb_sel
  );
  modport slave(
    input pc_req, sp_req, sp_dec, blk_start, blk_dec, idu_zero,
    output pc_gnt, sp_gnt, blk_busy, blk_done, blk_bc_zero, idu_valid, idu_dec, idu_sel, wb_en, wb_sel
  );
endinterface

// File: rtl/idu_blk_fsm.sv
// idu_blk_fsm: HL/DE/BC block-step sequencer with starvation counter and BC-zero latch
module idu_blk_fsm import idu_sched_pkg::*; (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_start,
  input  logic             i_dec,
  input  logic             i_hold,
  input  logic             i_zero,
  output logic             o_busy,
  output logic             o_issue,
  output logic             o_force,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_dec,
  output logic             o_done,
  output logic             o_bc_zero
);
  blk_state_e r_state, w_next;
  logic       r_dec, r_done, r_bc_zero;
  logic [2:0] r_stall;
  // next state and issue decision; a saturated stall count overrides PC/SP
  always_comb begin
    o_busy  = r_state != BLK_IDLE;
    o_force = o_busy && r_stall == STALL_LIMIT;
    o_issue = o_busy && (o_force || !i_hold);
    o_sel   = r_state == BLK_HL ? SEL_HL : r_state == BLK_DE ? SEL_DE : SEL_BC;
    o_dec   = r_state == BLK_BC ? 1'b1 : r_dec;
    w_next  = r_state == BLK_IDLE ? (i_start ? BLK_HL : BLK_IDLE) :
              !o_issue ? r_state :
              r_state == BLK_BC ? BLK_IDLE : blk_state_e'(r_state + 2'd1);
  end
  // state, latched direction, stall count, done pulse and BC-zero result
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= BLK_IDLE;
      r_dec     <= 1'b0;
      r_stall   <= 3'd0;
      r_done    <= 1'b0;
      r_bc_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == BLK_IDLE && i_start) r_dec <= i_dec;
      r_stall <= (!o_busy || o_issue) ? 3'd0 : o_force ? r_stall : r_stall + 3'd1;
      r_done  <= o_issue && r_state == BLK_BC;
      if (o_issue && r_state == BLK_BC) r_bc_zero <= i_zero;
    end
  end
  assign o_done    = r_done;
  assign o_bc_zero = r_bc_zero;
endmodule

// File: rtl/idu_sched.sv
// idu_sched: fixed-priority IDU arbiter (PC > SP > block) with one-cycle write-back
module idu_sched import idu_sched_pkg::*; (
  input logic       clk,
  input logic       nreset,
  idu_sched_if.slave bus
);
  logic             w_issue, w_force, w_blk_dec;
  logic [SEL_W-1:0] w_blk_sel;
  logic             r_wb_en;
  logic [SEL_W-1:0] r_wb_sel;
  idu_blk_fsm u_blk (
    .clk       (clk),
    .nreset    (nreset),
    .i_start   (bus.blk_start),
    .i_dec     (bus.blk_dec),
    .i_hold    (bus.pc_req | bus.sp_req),
    .i_zero    (bus.idu_zero),
    .o_busy    (bus.blk_busy),
    .o_issue   (w_issue),
    .o_force   (w_force),
    .o_sel     (w_blk_sel),
    .o_dec     (w_blk_dec),
    .o_done    (bus.blk_done),
    .o_bc_zero (bus.blk_bc_zero)
  );
  // grants and issue mux; a forced block issue masks both PC and SP
  always_comb begin
    bus.pc_gnt    = bus.pc_req && !w_force;
    bus.sp_gnt    = bus.sp_req && !bus.pc_req && !w_force;
    bus.idu_valid = bus.pc_gnt || bus.sp_gnt || w_issue;
    bus.idu_sel   = bus.sp_gnt ? SEL_SP : w_issue ? w_blk_sel : SEL_PC;
    bus.idu_dec   = bus.sp_gnt ? bus.sp_dec : w_issue ? w_blk_dec : 1'b0;
  end
  // write-back strobe and target follow the issue by one cycle
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_wb_en  <= 1'b0;
      r_wb_sel <= SEL_PC;
    end else begin
      r_wb_en  <= bus.idu_valid;
      r_wb_sel <= bus.idu_sel;
    end
  end
  assign bus.wb_en  = r_wb_en;
  assign bus.wb_sel = r_wb_sel;
endmodule

// File: tb/tb_idu_sched.sv
// tb_idu_sched: directed checks of arbitration, block sequencing, starvation and reset
module tb_idu_sched;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  idu_sched_if bus();
  idu_sched u_dut (.clk(clk), .nreset(nreset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_issue(input string tag, input logic v, input logic [2:0] s, input logic d);
    #1;
    check({tag, ".valid"}, 8'(bus.idu_valid), 8'(v));
    check({tag, ".sel"}, 8'(bus.idu_sel), 8'(s));
    check({tag, ".dec"}, 8'(bus.idu_dec), 8'(d));
  endtask
  initial begin
    bus.pc_req = 0; bus.sp_req = 0; bus.sp_dec = 0;
    bus.blk_start = 0; bus.blk_dec = 0; bus.idu_zero = 0;
    tick(); tick();
    chk_issue("rst", 0, 0, 0);
    check("rst.busy", 8'(bus.blk_busy), 0);
    check("rst.wb_en", 8'(bus.wb_en), 0);
    check("rst.done", 8'(bus.blk_done), 0);
    check("rst.bcz", 8'(bus.blk_bc_zero), 0);
    nreset = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.pc_req = 1;
      chk_issue("pc", 1, 0, 0);
      check("pc.gnt", 8'(bus.pc_gnt), 1);
      check("pc.wb_en", 8'(bus.wb_en), 8'(i > 0));
    end
    tick();
    bus.pc_req = 1; bus.sp_req = 1; bus.sp_dec = 1;
    chk_issue("pcsp", 1, 0, 0);
    check("pcsp.pc_gnt", 8'(bus.pc_gnt), 1);
    check("pcsp.sp_gnt", 8'(bus.sp_gnt), 0);
    check("pcsp.wb_sel", 8'(bus.wb_sel), 0);
    tick();
    bus.pc_req = 0;
    chk_issue("sp", 1, 1, 1);
    check("sp.gnt", 8'(bus.sp_gnt), 1);
    tick();
    bus.sp_req = 0;
    chk_issue("sp_idle", 0, 0, 0);
    check("sp.wb_en", 8'(bus.wb_en), 1);
    check("sp.wb_sel", 8'(bus.wb_sel), 1);
    tick();
    bus.blk_start = 1; bus.blk_dec = 0;
    chk_issue("b1.start", 0, 0, 0);
    check("b1.busy0", 8'(bus.blk_busy), 0);
    tick();
    bus.blk_start = 0; bus.idu_zero = 0;
    chk_issue("b1.hl", 1, 2, 0);
    check("b1.busy", 8'(bus.blk_busy), 1);
    tick();
    chk_issue("b1.de", 1, 3, 0);
    check("b1.wb_hl", 8'(bus.wb_sel), 2);
    tick();
    bus.idu_zero = 1;
    chk_issue("b1.bc", 1, 4, 1);
    tick();
    bus.idu_zero = 0;
    chk_issue("b1.end", 0, 0, 0);
    check("b1.done", 8'(bus.blk_done), 1);
    check("b1.busy_end", 8'(bus.blk_busy), 0);
    check("b1.wb_en", 8'(bus.wb_en), 1);
    check("b1.wb_bc", 8'(bus.wb_sel), 4);
    check("b1.bcz", 8'(bus.blk_bc_zero), 1);
    tick();
    #1;
    check("b1.done_pulse", 8'(bus.blk_done), 0);
    check("b1.bcz_hold", 8'(bus.blk_bc_zero), 1);
    bus.blk_start = 1; bus.blk_dec = 1; bus.idu_zero = 1;
    tick();
    bus.blk_start = 0;
    chk_issue("b2.hl", 1, 2, 1);
    tick();
    bus.pc_req = 1;
    chk_issue("b2.stall0", 1, 0, 0);
    check("b2.stall0.gnt", 8'(bus.pc_gnt), 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      #1;
      check("b2.stall.gnt", 8'(bus.pc_gnt), 1);
      check("b2.stall.sel", 8'(bus.idu_sel), 0);
    end
    tick();
    chk_issue("b2.force_de", 1, 3, 1);
    check("b2.force.gnt", 8'(bus.pc_gnt), 0);
    tick();
    bus.idu_zero = 0;
    chk_issue("b2.bc_stall", 1, 0, 0);
    check("b2.restart.gnt", 8'(bus.pc_gnt), 1);
    tick();
    bus.pc_req = 0;
    chk_issue("b2.bc", 1, 4, 1);
    tick();
    #1;
    check("b2.done", 8'(bus.blk_done), 1);
    check("b2.bcz", 8'(bus.blk_bc_zero), 0);
    tick();
    bus.blk_start = 1; bus.blk_dec = 0;
    tick();
    bus.blk_dec = 1;
    chk_issue("b3.hl", 1, 2, 0);
    tick();
    chk_issue("b3.de", 1, 3, 0);
    tick();
    bus.blk_start = 0; bus.idu_zero = 1;
    chk_issue("b3.bc", 1, 4, 1);
    tick();
    bus.idu_zero = 0;
    #1;
    check("b3.done", 8'(bus.blk_done), 1);
    check("b3.bcz", 8'(bus.blk_bc_zero), 1);
    tick();
    chk_issue("b3.idle", 0, 0, 0);
    check("b3.done_once", 8'(bus.blk_done), 0);
    check("b3.busy", 8'(bus.blk_busy), 0);
    tick();
    bus.blk_start = 1; bus.blk_dec = 0;
    tick();
    bus.blk_start = 0;
    chk_issue("b4.hl", 1, 2, 0);
    tick();
    chk_issue("b4.de", 1, 3, 0);
    nreset = 0;
    tick();
    nreset = 1;
    chk_issue("rst2", 0, 0, 0);
    check("rst2.busy", 8'(bus.blk_busy), 0);
    check("rst2.wb_en", 8'(bus.wb_en), 0);
    check("rst2.bcz", 8'(bus.blk_bc_zero), 0);
    tick();
    chk_issue("rst2.no_bc", 0, 0, 0);
    check("rst2.wb_en2", 8'(bus.wb_en), 0);
    check("rst2.done", 8'(bus.blk_done), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
